// File: rtl/zorro_write_queue.sv
// Zorro II graphics-RAM write buffer: queues captured bus writes and drains them
// as 32-bit-cell write commands to the SDRAM controller, yielding to scanline fetches.
module zorro_write_queue #(
  parameter int unsigned ADDR_W = 9
) (
  input  logic              z_sample_clk,
  input  logic              znRST,
  input  logic              wr_push,
  input  logic [23:0]       wr_addr,
  input  logic              wr_uds,
  input  logic              wr_lds,
  input  logic [15:0]       wr_data,
  input  logic              fetch_busy,
  input  logic              cmd_ready,
  output logic              cmd_enable,
  output logic              cmd_wr,
  output logic [3:0]        cmd_byte_enable,
  output logic [23:0]       cmd_address,
  output logic [31:0]       cmd_data_in,
  output logic [ADDR_W:0]   free_count,
  output logic              q_empty,
  output logic              q_full,
  output logic              overflow
);

  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam int unsigned CNT_W   = ADDR_W + 1;
  localparam int unsigned ENTRY_W = 42;

  typedef enum logic [1:0] {IDLE, LOAD, ISSUE, HOLDOFF} state_t;

  state_t              state, nextState;
  logic [ENTRY_W-1:0]  mem [DEPTH];
  logic [ENTRY_W-1:0]  rdEntry;
  logic [ADDR_W-1:0]   wrPtr, rdPtr;
  logic [CNT_W-1:0]    fillCount, fillNext_c;
  logic                strobe_c, pushOk_c, pushDrop_c;
  logic                startRead_c, load_c, pop_c;
  logic [23:0]         rdAddr_c;
  logic [15:0]         rdData_c;
  logic                rdUds_c, rdLds_c;

  assign strobe_c   = wr_uds | wr_lds;
  assign pushOk_c   = wr_push & strobe_c & ~q_full;
  assign pushDrop_c = wr_push & strobe_c & q_full;

  assign rdUds_c  = rdEntry[41];
  assign rdLds_c  = rdEntry[40];
  assign rdAddr_c = rdEntry[39:16];
  assign rdData_c = rdEntry[15:0];

  // Entry storage with registered read
  always_ff @(posedge z_sample_clk) begin
    if (pushOk_c) mem[wrPtr] <= {wr_uds, wr_lds, wr_addr, wr_data};
    if (startRead_c) rdEntry <= mem[rdPtr];
  end

  always_ff @(posedge z_sample_clk or negedge znRST) begin
    if (!znRST) state <= IDLE;
    else        state <= nextState;
  end

  // fetch_busy only gates the start of a new command
  always_comb begin
    nextState   = state;
    startRead_c = 1'b0;
    load_c      = 1'b0;
    pop_c       = 1'b0;
    case (state)
      IDLE: begin
        if (!q_empty && !fetch_busy && cmd_ready) begin
          startRead_c = 1'b1;
          nextState   = LOAD;
        end
      end
      LOAD: begin
        load_c    = 1'b1;
        nextState = ISSUE;
      end
      ISSUE: begin
        if (cmd_ready) begin
          pop_c     = 1'b1;
          nextState = HOLDOFF;
        end
      end
      HOLDOFF: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  assign fillNext_c = fillCount + CNT_W'(pushOk_c) - CNT_W'(pop_c);

  // Pointers, occupancy and status flags all move on the same edge
  always_ff @(posedge z_sample_clk or negedge znRST) begin
    if (!znRST) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      fillCount  <= '0;
      free_count <= CNT_W'(DEPTH);
      q_empty    <= 1'b1;
      q_full     <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (pushOk_c) wrPtr <= wrPtr + ADDR_W'(1);
      if (pop_c)    rdPtr <= rdPtr + ADDR_W'(1);
      if (pushDrop_c) overflow <= 1'b1;
      fillCount  <= fillNext_c;
      free_count <= CNT_W'(DEPTH) - fillNext_c;
      q_empty    <= (fillNext_c == '0);
      q_full     <= (fillNext_c == CNT_W'(DEPTH));
    end
  end

  // Command register: loaded from the RAM word, held until accepted
  always_ff @(posedge z_sample_clk or negedge znRST) begin
    if (!znRST) begin
      cmd_enable      <= 1'b0;
      cmd_wr          <= 1'b0;
      cmd_byte_enable <= '0;
      cmd_address     <= '0;
      cmd_data_in     <= '0;
    end else if (load_c) begin
      cmd_enable  <= 1'b1;
      cmd_wr      <= 1'b1;
      cmd_address <= 24'((rdAddr_c & 24'h1FFFFE) << 1);
      cmd_data_in <= {rdData_c, rdData_c};
      case ({rdUds_c, rdLds_c})
        2'b10:   cmd_byte_enable <= 4'b1010;
        2'b01:   cmd_byte_enable <= 4'b0101;
        2'b11:   cmd_byte_enable <= 4'b1111;
        default: cmd_byte_enable <= 4'b0000;
      endcase
    end else if (pop_c) begin
      cmd_enable <= 1'b0;
      cmd_wr     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_zorro_write_queue.sv
// Directed self-checking bench for zorro_write_queue (default 512-entry depth).
module tb_zorro_write_queue;

  logic        z_sample_clk = 1'b0;
  logic        znRST;
  logic        wr_push, wr_uds, wr_lds, fetch_busy, cmd_ready;
  logic [23:0] wr_addr;
  logic [15:0] wr_data;
  logic        cmd_enable, cmd_wr, q_empty, q_full, overflow;
  logic [3:0]  cmd_byte_enable;
  logic [23:0] cmd_address;
  logic [31:0] cmd_data_in;
  logic [9:0]  free_count;

  int checks = 0;
  int errors = 0;

  zorro_write_queue #(.ADDR_W(9)) dut (
    .z_sample_clk(z_sample_clk), .znRST(znRST),
    .wr_push(wr_push), .wr_addr(wr_addr), .wr_uds(wr_uds), .wr_lds(wr_lds),
    .wr_data(wr_data), .fetch_busy(fetch_busy), .cmd_ready(cmd_ready),
    .cmd_enable(cmd_enable), .cmd_wr(cmd_wr), .cmd_byte_enable(cmd_byte_enable),
    .cmd_address(cmd_address), .cmd_data_in(cmd_data_in), .free_count(free_count),
    .q_empty(q_empty), .q_full(q_full), .overflow(overflow)
  );

  always #5 z_sample_clk = ~z_sample_clk;

  task automatic tick();
    @(posedge z_sample_clk);
    #1;
  endtask

  task automatic push_word(input logic u, input logic l, input logic [23:0] a, input logic [15:0] d);
    wr_push = 1'b1; wr_uds = u; wr_lds = l; wr_addr = a; wr_data = d;
    tick();
    wr_push = 1'b0; wr_uds = 1'b0; wr_lds = 1'b0;
  endtask

  task automatic wait_cmd(input int budget, output bit got);
    for (int k = 0; k < budget && !cmd_enable; k++) tick();
    got = cmd_enable;
  endtask

  task automatic test_reset();
    checks++;
    if (cmd_enable !== 1'b0 || cmd_wr !== 1'b0 || cmd_byte_enable !== 4'd0 ||
        cmd_address !== 24'd0 || cmd_data_in !== 32'd0) begin
      errors++;
      $display("FAIL reset_cmd en=%b wr=%b be=%b addr=%h data=%h expected all zero",
               cmd_enable, cmd_wr, cmd_byte_enable, cmd_address, cmd_data_in);
    end
    checks++;
    if (free_count !== 10'd512 || q_empty !== 1'b1 || q_full !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_status free=%0d empty=%b full=%b ovf=%b expected 512 1 0 0",
               free_count, q_empty, q_full, overflow);
    end
  endtask

  task automatic test_single();
    cmd_ready = 1'b1; fetch_busy = 1'b0;
    push_word(1'b1, 1'b1, 24'h200004, 16'hABCD);
    checks++;
    if (q_empty !== 1'b0 || free_count !== 10'd511) begin
      errors++;
      $display("FAIL single_push empty=%b free=%0d expected 0 511", q_empty, free_count);
    end
    tick();
    checks++;
    if (cmd_enable !== 1'b0) begin
      errors++;
      $display("FAIL single_early en=%b expected 0", cmd_enable);
    end
    tick();
    checks++;
    if (cmd_enable !== 1'b1 || cmd_wr !== 1'b1 || cmd_address !== 24'h000008 ||
        cmd_byte_enable !== 4'b1111 || cmd_data_in !== 32'hABCDABCD) begin
      errors++;
      $display("FAIL single_cmd en=%b wr=%b addr=%h be=%b data=%h expected 1 1 000008 1111 abcdabcd",
               cmd_enable, cmd_wr, cmd_address, cmd_byte_enable, cmd_data_in);
    end
    tick();
    checks++;
    if (cmd_enable !== 1'b0 || cmd_wr !== 1'b0 || free_count !== 10'd512 || q_empty !== 1'b1) begin
      errors++;
      $display("FAIL single_accept en=%b wr=%b free=%0d empty=%b expected 0 0 512 1",
               cmd_enable, cmd_wr, free_count, q_empty);
    end
    tick();
  endtask

  task automatic test_byte_lanes();
    bit got;
    bit seen;
    cmd_ready = 1'b1; fetch_busy = 1'b0;
    push_word(1'b1, 1'b0, 24'h2FFFFE, 16'h1234);
    push_word(1'b0, 1'b1, 24'h300000, 16'h5678);
    push_word(1'b0, 1'b0, 24'h200010, 16'h9999);
    wait_cmd(20, got);
    checks++;
    if (!got || cmd_byte_enable !== 4'b1010 || cmd_address !== 24'h1FFFFC || cmd_data_in !== 32'h12341234) begin
      errors++;
      $display("FAIL lanes_uds got=%b be=%b addr=%h data=%h expected 1 1010 1ffffc 12341234",
               got, cmd_byte_enable, cmd_address, cmd_data_in);
    end
    tick();
    wait_cmd(20, got);
    checks++;
    if (!got || cmd_byte_enable !== 4'b0101 || cmd_address !== 24'h200000 || cmd_data_in !== 32'h56785678) begin
      errors++;
      $display("FAIL lanes_lds got=%b be=%b addr=%h data=%h expected 1 0101 200000 56785678",
               got, cmd_byte_enable, cmd_address, cmd_data_in);
    end
    tick();
    seen = 1'b0;
    repeat (12) begin
      tick();
      if (cmd_enable) seen = 1'b1;
    end
    checks++;
    if (seen || q_empty !== 1'b1 || free_count !== 10'd512) begin
      errors++;
      $display("FAIL lanes_nostrobe extra_cmd=%b empty=%b free=%0d expected 0 1 512", seen, q_empty, free_count);
    end
  endtask

  task automatic test_fetch_yield();
    bit got;
    bit seen;
    cmd_ready = 1'b1; fetch_busy = 1'b1;
    push_word(1'b1, 1'b1, 24'h200100, 16'h1111);
    push_word(1'b1, 1'b1, 24'h200102, 16'h2222);
    push_word(1'b1, 1'b1, 24'h200104, 16'h3333);
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (cmd_enable) seen = 1'b1;
    end
    checks++;
    if (seen || free_count !== 10'd509) begin
      errors++;
      $display("FAIL fetch_hold cmd_seen=%b free=%0d expected 0 509", seen, free_count);
    end
    fetch_busy = 1'b0;
    wait_cmd(10, got);
    checks++;
    if (!got || cmd_address !== 24'h000200 || cmd_data_in !== 32'h11111111) begin
      errors++;
      $display("FAIL fetch_first got=%b addr=%h data=%h expected 1 000200 11111111", got, cmd_address, cmd_data_in);
    end
    fetch_busy = 1'b1; cmd_ready = 1'b0;
    tick(); tick();
    checks++;
    if (cmd_enable !== 1'b1 || cmd_address !== 24'h000200 || cmd_data_in !== 32'h11111111) begin
      errors++;
      $display("FAIL fetch_issue_hold en=%b addr=%h data=%h expected 1 000200 11111111", cmd_enable, cmd_address, cmd_data_in);
    end
    cmd_ready = 1'b1;
    tick();
    checks++;
    if (cmd_enable !== 1'b0 || free_count !== 10'd510) begin
      errors++;
      $display("FAIL fetch_issue_done en=%b free=%0d expected 0 510", cmd_enable, free_count);
    end
    seen = 1'b0;
    repeat (4) begin
      tick();
      if (cmd_enable) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL fetch_reyield cmd_seen=%b expected 0", seen);
    end
    fetch_busy = 1'b0;
    wait_cmd(10, got);
    checks++;
    if (!got || cmd_address !== 24'h000204 || cmd_data_in !== 32'h22222222) begin
      errors++;
      $display("FAIL fetch_second got=%b addr=%h data=%h expected 1 000204 22222222", got, cmd_address, cmd_data_in);
    end
    tick();
    wait_cmd(10, got);
    checks++;
    if (!got || cmd_address !== 24'h000208 || cmd_data_in !== 32'h33333333) begin
      errors++;
      $display("FAIL fetch_third got=%b addr=%h data=%h expected 1 000208 33333333", got, cmd_address, cmd_data_in);
    end
    tick();
  endtask

  task automatic test_overflow();
    bit got;
    cmd_ready = 1'b0; fetch_busy = 1'b0;
    for (int i = 0; i < 513; i++) begin
      push_word(1'b1, 1'b1, 24'h200000 + 24'(2 * i), 16'(i));
      if (i == 511) begin
        checks++;
        if (q_full !== 1'b1 || free_count !== 10'd0 || overflow !== 1'b0) begin
          errors++;
          $display("FAIL ovf_at_full full=%b free=%0d ovf=%b expected 1 0 0", q_full, free_count, overflow);
        end
      end
    end
    checks++;
    if (q_full !== 1'b1 || free_count !== 10'd0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_dropped full=%b free=%0d ovf=%b expected 1 0 1", q_full, free_count, overflow);
    end
    cmd_ready = 1'b1;
    for (int i = 0; i < 512; i++) begin
      wait_cmd(10, got);
      checks++;
      if (!got || cmd_address !== 24'(4 * i) || cmd_data_in !== {16'(i), 16'(i)}) begin
        errors++;
        $display("FAIL ovf_drain idx=%0d got=%b addr=%h data=%h expected addr=%h data=%h",
                 i, got, cmd_address, cmd_data_in, 24'(4 * i), {16'(i), 16'(i)});
      end
      tick();
    end
    wait_cmd(12, got);
    checks++;
    if (got || q_empty !== 1'b1 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_after extra_cmd=%b empty=%b ovf=%b expected 0 1 1", got, q_empty, overflow);
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 40;
    int i = 0;
    int j = 0;
    int cyc = 0;
    logic preEn, preReady, pushed;
    logic [3:0]  preBe, expBe;
    logic [23:0] preAddr;
    logic [31:0] preData;
    logic [9:0]  preFree, expFree;
    logic [15:0] expD;
    fetch_busy = 1'b0;
    while ((i < N || j < N) && cyc < 2000) begin
      pushed = (i < N);
      if (pushed) begin
        wr_push = 1'b1;
        wr_uds  = (i % 3) != 2;
        wr_lds  = (i % 3) != 1;
        wr_addr = 24'h200000 + 24'(2 * i);
        wr_data = 16'h0100 + 16'(i);
      end
      cmd_ready = 1'($urandom_range(0, 1));
      preEn = cmd_enable; preReady = cmd_ready; preBe = cmd_byte_enable;
      preAddr = cmd_address; preData = cmd_data_in; preFree = free_count;
      tick();
      wr_push = 1'b0;
      if (pushed) i++;
      cyc++;
      if (preEn && preReady) begin
        expBe = ((j % 3) == 0) ? 4'b1111 : ((j % 3) == 1) ? 4'b1010 : 4'b0101;
        expD  = 16'h0100 + 16'(j);
        checks++;
        if (preAddr !== 24'(4 * j) || preData !== {expD, expD} || preBe !== expBe) begin
          errors++;
          $display("FAIL b2b_order idx=%0d addr=%h data=%h be=%b expected %h %h %b",
                   j, preAddr, preData, preBe, 24'(4 * j), {expD, expD}, expBe);
        end
        j++;
      end else if (preEn) begin
        checks++;
        if (cmd_enable !== 1'b1 || cmd_address !== preAddr || cmd_data_in !== preData || cmd_byte_enable !== preBe) begin
          errors++;
          $display("FAIL b2b_stable en=%b addr=%h data=%h be=%b expected 1 %h %h %b",
                   cmd_enable, cmd_address, cmd_data_in, cmd_byte_enable, preAddr, preData, preBe);
        end
      end
      expFree = preFree - 10'(pushed) + 10'(preEn && preReady);
      checks++;
      if (free_count !== expFree) begin
        errors++;
        $display("FAIL b2b_free cyc=%0d free=%0d expected %0d", cyc, free_count, expFree);
      end
    end
    checks++;
    if (j != N) begin
      errors++;
      $display("FAIL b2b_drained drained=%0d expected %0d", j, N);
    end
    cmd_ready = 1'b1;
    repeat (6) tick();
    checks++;
    if (q_empty !== 1'b1 || free_count !== 10'd512 || cmd_enable !== 1'b0) begin
      errors++;
      $display("FAIL b2b_final empty=%b free=%0d en=%b expected 1 512 0", q_empty, free_count, cmd_enable);
    end
  endtask

  task automatic test_reset_issue();
    bit got;
    bit seen;
    cmd_ready = 1'b1; fetch_busy = 1'b0;
    push_word(1'b1, 1'b1, 24'h200020, 16'hAAAA);
    push_word(1'b1, 1'b1, 24'h200022, 16'hBBBB);
    wait_cmd(10, got);
    cmd_ready = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL rst_issue_setup got=%b expected 1", got);
    end
    #2 znRST = 1'b0;
    #1;
    checks++;
    if (cmd_enable !== 1'b0 || cmd_wr !== 1'b0 || cmd_address !== 24'd0 || q_empty !== 1'b1 ||
        free_count !== 10'd512 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL rst_async en=%b wr=%b addr=%h empty=%b free=%0d ovf=%b expected 0 0 000000 1 512 0",
               cmd_enable, cmd_wr, cmd_address, q_empty, free_count, overflow);
    end
    @(negedge z_sample_clk);
    znRST = 1'b1;
    cmd_ready = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      tick();
      if (cmd_enable) seen = 1'b1;
    end
    checks++;
    if (seen || q_empty !== 1'b1 || overflow !== 1'b0 || free_count !== 10'd512) begin
      errors++;
      $display("FAIL rst_after cmd_seen=%b empty=%b ovf=%b free=%0d expected 0 1 0 512",
               seen, q_empty, overflow, free_count);
    end
  endtask

  initial begin
    znRST = 1'b0; wr_push = 1'b0; wr_uds = 1'b0; wr_lds = 1'b0;
    wr_addr = '0; wr_data = '0; fetch_busy = 1'b0; cmd_ready = 1'b0;
    repeat (3) @(posedge z_sample_clk);
    @(negedge z_sample_clk);
    znRST = 1'b1;
    tick();
    test_reset();
    test_single();
    test_byte_lanes();
    test_fetch_yield();
    test_overflow();
    test_back_to_back();
    test_reset_issue();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
